riscv_decode_stage: RTL and testbench

Registered RV32I/RV64I instruction-decode pipeline stage with a valid/ready handshake on both sides. It sits between the fetch stage and the register-file/execute stage. It extracts register indices and control fields, classifies the instruction format, and outputs a fully assembled, sign-extended immediate at XLEN width. It also flags illegal encodings, and it replaces the earlier combinational field splitter that emitted raw immediate fragments.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/riscv_imm_gen.sv | 36 +++
 rtl/riscv_decode_stage.sv | 128 ++++++++++++
 tb/tb_riscv_decode_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared decode definitions: instruction format codes, RV32I/RV64I major opcodes,
// and the opcode-to-format classification used by the decode stage.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;

  // Every mapped opcode ends in 2'b11, so compressed encodings fall through to FMT_NONE.
  function automatic fmt_e opcode_fmt(input logic [6:0] op, input logic rv64);
    fmt_e f;
    f = FMT_NONE;
    case (op)
      OP_OP:                                           f = FMT_R;
      OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: f = FMT_I;
      OP_STORE:                                        f = FMT_S;
      OP_BRANCH:                                       f = FMT_B;
      OP_LUI, OP_AUIPC:                                f = FMT_U;
      OP_JAL:                                          f = FMT_J;
      OP_OPIMM32:                                      f = rv64 ? FMT_I : FMT_NONE;
      OP_OP32:                                         f = rv64 ? FMT_R : FMT_NONE;
      default:                                         f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate assembler: builds the sign-extended XLEN-wide immediate
// for an instruction word given its already-classified format.
module riscv_imm_gen import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;
  logic        unusedOpcode;

  assign unusedOpcode = ^instr_i[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      FMT_U: imm32 = {instr_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widen to XLEN by replicating bit 31 into the upper half when XLEN is 64.
  always_comb begin
    imm_o       = {XLEN{imm32[31]}};
    imm_o[31:0] = imm32;
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready handshake on both sides.
// Optional accept/illegal counters are enabled by defining DECODE_STATS_EN.
module riscv_decode_stage import riscv_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_illegal,
  output logic [31:0]     stat_decoded,
  output logic [31:0]     stat_illegal
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  fmt_e            fmt_q;
  logic [XLEN-1:0] imm_q;
  logic            rdWe_q;
  logic            illegal_q;

  logic            accept;
  logic            load;
  fmt_e            decFmt;
  logic [XLEN-1:0] decImm;
  logic            decRdWe;
  logic            decIllegal;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && !flush;

  always_comb begin
    decFmt     = opcode_fmt(in_instr[6:0], 1'(XLEN == 64));
    decIllegal = (decFmt == FMT_NONE);
    decRdWe    = (decFmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) &&
                 (in_instr[11:7] != 5'd0) &&
                 (in_instr[6:0] != OP_SYSTEM) && (in_instr[6:0] != OP_FENCE);
  end

  riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (in_instr),
    .fmt_i   (decFmt),
    .imm_o   (decImm)
  );

  // Flush beats a same-cycle accept; a drain without a new accept empties the stage.
  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      fmt_q     <= FMT_NONE;
      imm_q     <= '0;
      rdWe_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        pc_q      <= in_pc;
        instr_q   <= in_instr;
        fmt_q     <= decFmt;
        imm_q     <= decImm;
        rdWe_q    <= decRdWe;
        illegal_q <= decIllegal;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_opcode  = instr_q[6:0];
  assign out_funct3  = instr_q[14:12];
  assign out_funct7  = instr_q[31:25];
  assign out_rd      = instr_q[11:7];
  assign out_rs1     = instr_q[19:15];
  assign out_rs2     = instr_q[24:20];
  assign out_fmt     = fmt_q;
  assign out_imm     = imm_q;
  assign out_rd_we   = rdWe_q;
  assign out_illegal = illegal_q;

`ifdef DECODE_STATS_EN
  logic [31:0] statDecoded_q;
  logic [31:0] statIllegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statDecoded_q <= '0;
      statIllegal_q <= '0;
    end else if (load) begin
      statDecoded_q <= statDecoded_q + 32'd1;
      if (decIllegal) statIllegal_q <= statIllegal_q + 32'd1;
    end
  end

  assign stat_decoded = statDecoded_q;
  assign stat_illegal = statIllegal_q;
`else
  assign stat_decoded = '0;
  assign stat_illegal = '0;
`endif

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Self-checking bench for riscv_decode_stage (XLEN=32): table-driven decode vectors
// streamed back-to-back, then hand-written backpressure, flush and reset sequences.
module tb_riscv_decode_stage;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0080;
  localparam int          NV       = 12;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_fmt;
  logic [31:0] out_imm;
  logic        out_rd_we;
  logic        out_illegal;
  logic [31:0] stat_decoded;
  logic [31:0] stat_illegal;

  int testsRun;
  int testsFailed;
  int expDecoded;
  int expIllegal;

  riscv_decode_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7   (out_funct7),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_fmt      (out_fmt),
    .out_imm      (out_imm),
    .out_rd_we    (out_rd_we),
    .out_illegal  (out_illegal),
    .stat_decoded (stat_decoded),
    .stat_illegal (stat_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        rdWe;
    logic        illegal;
  } vec_t;

  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic checkVector(input vec_t v, input logic [31:0] pc);
    checkOutput("valid",   32'(out_valid),   32'd1);
    checkOutput("pc",      out_pc,           pc);
    checkOutput("opcode",  32'(out_opcode),  32'(v.opcode));
    checkOutput("funct3",  32'(out_funct3),  32'(v.funct3));
    checkOutput("funct7",  32'(out_funct7),  32'(v.funct7));
    checkOutput("rd",      32'(out_rd),      32'(v.rd));
    checkOutput("rs1",     32'(out_rs1),     32'(v.rs1));
    checkOutput("rs2",     32'(out_rs2),     32'(v.rs2));
    checkOutput("fmt",     32'(out_fmt),     32'(v.fmt));
    checkOutput("imm",     out_imm,          v.imm);
    checkOutput("rd_we",   32'(out_rd_we),   32'(v.rdWe));
    checkOutput("illegal", 32'(out_illegal), 32'(v.illegal));
  endtask

  task automatic checkStats(input string tag);
`ifdef DECODE_STATS_EN
    checkOutput({tag, "_stat_decoded"}, stat_decoded, 32'(expDecoded));
    checkOutput({tag, "_stat_illegal"}, stat_illegal, 32'(expIllegal));
`else
    checkOutput({tag, "_stat_decoded"}, stat_decoded, 32'd0);
    checkOutput({tag, "_stat_illegal"}, stat_illegal, 32'd0);
`endif
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    expDecoded  = 0;
    expIllegal  = 0;

    //          instr                                                                  opc       f3    f7     rd     rs1    rs2    fmt   imm           we    ill
    vecs[0]  = '{{7'b0000111, 5'b10101, 5'b01101, 3'b111, 5'b01101, 7'b1100011},     7'h63, 3'd7, 7'd7,   5'd13, 5'd13, 5'd21, 3'd3, 32'h0000_08EC, 1'b0, 1'b0};
    vecs[1]  = '{{12'b001000001001, 5'b10011, 3'b000, 5'b00111, 7'b0000011},          7'h03, 3'd0, 7'd16,  5'd7,  5'd19, 5'd9,  3'd1, 32'h0000_0209, 1'b1, 1'b0};
    vecs[2]  = '{32'hFFF0_0093,                                                        7'h13, 3'd0, 7'd127, 5'd1,  5'd0,  5'd31, 3'd1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{{7'b0000111, 5'b00000, 5'b01101, 3'b010, 5'b11101, 7'b0100011},     7'h23, 3'd2, 7'd7,   5'd29, 5'd13, 5'd0,  3'd2, 32'h0000_00FD, 1'b0, 1'b0};
    vecs[4]  = '{{20'b00001111010101101011, 5'b01101, 7'b0110111},                     7'h37, 3'd3, 7'd7,   5'd13, 5'd13, 5'd21, 3'd4, 32'h0F56_B000, 1'b1, 1'b0};
    vecs[5]  = '{{20'b00001111110101101110, 5'b01101, 7'b1101111},                     7'h6F, 3'd6, 7'd7,   5'd13, 5'd13, 5'd29, 3'd5, 32'h0006_E8FC, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000_006F,                                                        7'h6F, 3'd0, 7'd0,   5'd0,  5'd0,  5'd0,  3'd5, 32'h0000_0000, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000_22F3,                                                        7'h73, 3'd2, 7'd0,   5'd5,  5'd0,  5'd0,  3'd1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_0000,                                                        7'h00, 3'd0, 7'd0,   5'd0,  5'd0,  5'd0,  3'd6, 32'h0000_0000, 1'b0, 1'b1};
    vecs[9]  = '{32'hFFFF_FFFF,                                                        7'h7F, 3'd7, 7'd127, 5'd31, 5'd31, 5'd31, 3'd6, 32'h0000_0000, 1'b0, 1'b1};
    vecs[10] = '{32'h0000_003B,                                                        7'h3B, 3'd0, 7'd0,   5'd0,  5'd0,  5'd0,  3'd6, 32'h0000_0000, 1'b0, 1'b1};
    vecs[11] = '{{7'b1111111, 5'b00010, 5'b00001, 3'b000, 5'b11001, 7'b0100011},     7'h23, 3'd0, 7'd127, 5'd25, 5'd1,  5'd2,  3'd2, 32'hFFFF_FFF9, 1'b0, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_valid",    32'(out_valid),   32'd0);
    checkOutput("reset_pc",       out_pc,           RESET_PC);
    checkOutput("reset_fmt",      32'(out_fmt),     32'd6);
    checkOutput("reset_imm",      out_imm,          32'd0);
    checkOutput("reset_opcode",   32'(out_opcode),  32'd0);
    checkOutput("reset_rd_we",    32'(out_rd_we),   32'd0);
    checkOutput("reset_illegal",  32'(out_illegal), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready),    32'd1);
    checkStats("reset");
    rst_n = 1'b1;

    // Back-to-back stream: each vector's result is checked one cycle after it is driven.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) checkVector(vecs[i-1], 32'h1000 + 32'(4 * (i - 1)));
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      if (i < NV) begin
        applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
        expDecoded++;
        if (vecs[i].illegal) expIllegal++;
      end else begin
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
    end
    @(negedge clk);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkStats("stream");

    // Backpressure: held word must stay put while the next one waits at the input.
    applyStimulus(1'b1, vecs[0].instr, 32'h2000, 1'b1, 1'b0);
    expDecoded++;
    @(negedge clk);
    applyStimulus(1'b1, vecs[1].instr, 32'h2004, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("stall_in_ready", 32'(in_ready),  32'd0);
      checkOutput("stall_valid",    32'(out_valid), 32'd1);
      checkOutput("stall_pc",       out_pc,         32'h2000);
      checkOutput("stall_imm",      out_imm,        vecs[0].imm);
      checkOutput("stall_fmt",      32'(out_fmt),   32'(vecs[0].fmt));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    expDecoded++;
    @(negedge clk);
    checkVector(vecs[1], 32'h2004);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("release_drain_valid", 32'(out_valid), 32'd0);

    // Flush together with an accept drops the incoming word.
    applyStimulus(1'b1, vecs[2].instr, 32'h3000, 1'b1, 1'b1);
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("flush_accept_valid", 32'(out_valid), 32'd0);
    checkStats("flush");

    // Flush of a stalled word.
    applyStimulus(1'b1, vecs[3].instr, 32'h3004, 1'b0, 1'b0);
    expDecoded++;
    @(negedge clk);
    checkOutput("pre_flush_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_flush_pc",    out_pc,         32'h3004);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush_stall_valid", 32'(out_valid), 32'd0);
    checkStats("flush_stall");

    // Asynchronous reset in the middle of a stall.
    applyStimulus(1'b1, vecs[4].instr, 32'h4000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expDecoded = 0;
    expIllegal = 0;
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_pc",    out_pc,         RESET_PC);
    checkOutput("async_reset_fmt",   32'(out_fmt),   32'd6);
    checkOutput("async_reset_imm",   out_imm,        32'd0);
    checkStats("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, vecs[5].instr, 32'h5000, 1'b1, 1'b0);
    expDecoded++;
    @(negedge clk);
    checkVector(vecs[5], 32'h5000);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkStats("post_reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
